uart_tx_fifo: RTL and testbench

// - Byte queue and start sequencer sitting directly upstream of the Uart8 transmitter.
// - Host logic pushes bytes at clock rate.
// - The block drains them one at a time into Uart8's txIn/txStart/txBusy interface, so no frames are lost

---
 rtl/uart_tx_fifo_pkg.sv | 13 +
 rtl/uart_tx_fifo_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 93 +++++++++
 tb/tb_uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the UART transmit queue and its start sequencer.
package uart_tx_fifo_pkg;

  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned ByteW        = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StSend  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with a combinational head, separate level counter and sticky overflow flag.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned Width = ByteW,
  parameter int unsigned Depth = DefaultDepth
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         din_i,
  output logic [Width-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     overflow_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   level_q;
  logic             ovf_q;
  logic             push_ok, pop_ok;

  assign full_o     = (level_q == (AddrW+1)'(Depth));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = ovf_q;
  assign dout_o     = mem_q[rptr_q];

  // No pass-through: a push into a full queue is dropped even if a pop happens the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AddrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (AddrW+1)'(1);
        2'b01:   level_q <= level_q - (AddrW+1)'(1);
        default: level_q <= level_q;
      endcase
      if (push_i && full_o) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding a Uart8 transmitter: pops one byte per frame and holds txStart until busy.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [ByteW-1:0]       wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o,
  output logic                   overflow_o,
  output logic                   tx_start_o,
  output logic [ByteW-1:0]       tx_in_o,
  input  logic                   tx_busy_i,
  input  logic                   tx_done_i
);

  tx_state_e        state_q, state_d;
  logic             tx_start_q, tx_start_d;
  logic [ByteW-1:0] tx_in_q, tx_in_d;
  logic             pop;
  logic [ByteW-1:0] head;
  logic             unused_tx_done;

  // Frame completion is keyed on tx_busy_i falling.
  assign unused_tx_done = tx_done_i;

  sync_fifo #(
    .Width(ByteW),
    .Depth(Depth)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .push_i    (wr_en_i),
    .pop_i     (pop),
    .din_i     (wr_data_i),
    .dout_o    (head),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .level_o   (level_o),
    .overflow_o(overflow_o)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_in_d    = tx_in_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i && !empty_o && !tx_busy_i) begin
          pop        = 1'b1;
          tx_in_d    = head;
          tx_start_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tx_busy_i) begin
          tx_start_d = 1'b0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (!tx_busy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // flush_i leaves the sequencer alone so an in-flight frame completes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      tx_start_q <= 1'b0;
      tx_in_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_in_q    <= tx_in_d;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_in_o    = tx_in_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed checks of uart_tx_fifo against a queue-based model and a Uart8 stand-in.
module tb_uart_tx_fifo;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       rst, en, flush, wr_en, tx_busy, tx_done;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start;
  logic [4:0] level;
  logic [7:0] tx_in;

  always #5 clk = ~clk;

  uart_tx_fifo #(.Depth(Depth)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .en_i      (en),
    .flush_i   (flush),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level),
    .overflow_o(overflow),
    .tx_start_o(tx_start),
    .tx_in_o   (tx_in),
    .tx_busy_i (tx_busy),
    .tx_done_i (tx_done)
  );

  // Model: queued bytes, sticky overflow, and whether a frame is requested / in progress.
  logic [7:0] mq[$];
  bit         m_ovf, m_start, m_in_frame;
  logic [7:0] m_txin;
  // Uart8 stand-in: busy for frame_len cycles after it sees a start request.
  int         busy_cnt, frame_len;
  logic [7:0] sent[$];
  logic [7:0] rx_byte;
  int         vectors, miscompares;
  int         max_level;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    bit         do_pop;
    logic [7:0] head;
    int         sz;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_start = 0; m_in_frame = 0; m_txin = 8'h00;
      return;
    end
    sz     = mq.size();
    do_pop = !m_in_frame && en && sz != 0 && !tx_busy;
    head   = 8'h00;
    if (do_pop) head = mq[0];
    if (m_start && tx_busy) m_start = 0;
    else if (m_in_frame && !m_start && !tx_busy) m_in_frame = 0;
    if (do_pop) begin
      m_in_frame = 1; m_start = 1; m_txin = head;
    end
    if (flush) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (wr_en) begin
        if (sz < Depth) mq.push_back(wr_data);
        else m_ovf = 1;
      end
    end
  endfunction

  task automatic tick();
    bit         start_pre, busy_pre;
    logic [7:0] txin_pre;
    @(negedge clk);
    start_pre = m_start;
    busy_pre  = tx_busy;
    txin_pre  = m_txin;
    model_step();
    chk("full", full, (mq.size() == Depth));
    chk("empty", empty, (mq.size() == 0));
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("tx_start", tx_start, m_start);
    chk("tx_in", tx_in, m_txin);
    if (int'(level) > max_level) max_level = int'(level);
    if (busy_pre) busy_cnt--;
    else if (start_pre) begin
      busy_cnt = frame_len;
      rx_byte  = txin_pre;
      sent.push_back(txin_pre);
    end
    tx_busy = (busy_cnt > 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || m_in_frame || busy_cnt != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!tx_busy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [7:0] burst[4];
  int         en_bias, n;

  initial begin
    vectors = 0; miscompares = 0; busy_cnt = 0; frame_len = 3; max_level = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    tx_busy = 1'b0; tx_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_in", tx_in, 8'h00);

    // Single byte: start one cycle after the push edge, drop after busy rises.
    en = 1'b1;
    push(8'h45);
    chk("single_level", level, 1);
    chk("single_no_start_yet", tx_start, 0);
    tick();
    chk("single_start", tx_start, 1);
    chk("single_txin", tx_in, 8'h45);
    tick();
    chk("single_start_hold", tx_start, 1);
    tick();
    chk("single_start_drop", tx_start, 0);
    chk("single_rx", rx_byte, 8'h45);
    drain();

    // Burst with a simultaneous push/pop on the second byte.
    burst[0] = 8'hA5; burst[1] = 8'h5A; burst[2] = 8'hFF; burst[3] = 8'h00;
    sent.delete(); max_level = 0;
    for (int i = 0; i < 4; i++) begin
      push(burst[i]);
      if (i == 1) chk("simul_level", level, 1);
    end
    drain();
    chk("burst_count", sent.size(), 4);
    for (int i = 0; i < 4; i++) chk("burst_order", sent[i], burst[i]);
    chk("burst_peak", max_level, 3);

    // Fill past capacity with the sequencer held off.
    en = 1'b0; sent.delete();
    for (int i = 0; i <= Depth; i++) push(8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    en = 1'b1;
    drain();
    chk("ovf_sent_count", sent.size(), 16);
    for (int i = 0; i < 16; i++) chk("ovf_sent_byte", sent[i], i);

    // Flush mid-frame: the current frame finishes, nothing else starts.
    en = 1'b0; sent.delete();
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1;
    wait_busy();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty", empty, 1);
    chk("flush_overflow", overflow, 0);
    drain();
    chk("flush_sent_count", sent.size(), 1);
    chk("flush_sent_byte", sent[0], 8'h11);

    // Reset mid-frame with two bytes queued.
    frame_len = 8; en = 1'b0;
    push(8'h66); push(8'h77); push(8'h88);
    en = 1'b1;
    wait_busy();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_tx_start", tx_start, 0);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_busy_still", tx_busy, 1);
    push(8'h99);
    n = 0;
    while (!tx_start && n < 100) begin
      tick();
      n++;
    end
    chk("rstmid_started", tx_start, 1);
    chk("rstmid_txin", tx_in, 8'h99);
    chk("rstmid_busy_done", tx_busy, 0);
    drain();

    // Random traffic.
    en_bias = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) en_bias = int'($urandom_range(10, 100));
      en        = ($urandom_range(0, 99) < en_bias);
      wr_en     = ($urandom_range(0, 99) < 55);
      wr_data   = 8'($urandom);
      flush     = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      frame_len = int'($urandom_range(1, 5));
      tick();
    end
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; en = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
